// File: rtl/keccak_dom_pkg.sv
// -----------------------------------------------------------------------------
// keccak_dom_pkg
// Shared helpers for the masked (DOM) Keccak chi/iota datapath.
//   calc_num_rand(shares) : fresh-mask pairs per row bit, shares*(shares-1)/2
//   calc_beats(w, rows)   : beats per Keccak-f round, 5*w/rows
//   rand_idx(i, j)        : mask-pair index of the unordered share pair {i, j}
//   share_off / rand_off  : flat bit offsets of the share and mask buses
//   term_off              : bit offset of one stage-1 term inside a row's term bus
// -----------------------------------------------------------------------------
package keccak_dom_pkg;

    function automatic int calc_num_rand(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    function automatic int calc_beats(input int w, input int rows);
        return 5 * w / rows;
    endfunction

    // Both orderings (i,j) and (j,i) map to the same pair so each fresh mask
    // is used exactly twice and cancels in the unmasked sum.
    function automatic int rand_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo + hi * (hi - 1) / 2;
    endfunction

    // Share s, row k, bit x on the data buses.
    function automatic int share_off(input int s, input int k, input int x, input int rows);
        return (s * rows + k) * 5 + x;
    endfunction

    // Pair p, row k, bit x on the randomness bus.
    function automatic int rand_off(input int p, input int k, input int x, input int rows);
        return (p * rows + k) * 5 + x;
    endfunction

    // Ordered pair (i, j), bit x inside one row's stage-1 term vector.
    function automatic int term_off(input int i, input int j, input int x, input int shares);
        return (i * shares + j) * 5 + x;
    endfunction

endpackage

// File: rtl/keccak_chi_dom_row.sv
// -----------------------------------------------------------------------------
// keccak_chi_dom_row
// Combinational DOM stage-1 term generation for one 5-bit chi row.
//   shares_i : share s, bit x at s*5+x
//   z_i      : fresh mask pair p, bit x at p*5+x
//   iota_i   : round-constant bit folded into share 0, bit 0
//   terms_o  : ordered pair (i,j), bit x at (i*SHARES+j)*5+x
// Cross-domain terms are S_i[x+1] & S_j[x+2] ^ Z; inner-domain terms are the
// share's own chi. The caller registers the terms before any XOR compression.
// -----------------------------------------------------------------------------
module keccak_chi_dom_row
    import keccak_dom_pkg::*;
#(
    parameter int SHARES   = 2,
    parameter int NUM_RAND = calc_num_rand(SHARES)
) (
    input  logic [SHARES*5-1:0]        shares_i,
    input  logic [NUM_RAND*5-1:0]      z_i,
    input  logic                       iota_i,
    output logic [SHARES*SHARES*5-1:0] terms_o
);

    for (genvar gi = 0; gi < SHARES; gi++) begin : g_i
        for (genvar gj = 0; gj < SHARES; gj++) begin : g_j
            for (genvar gx = 0; gx < 5; gx++) begin : g_x
                localparam int X1 = (gx + 1) % 5;
                localparam int X2 = (gx + 2) % 5;
                localparam int T  = term_off(gi, gj, gx, SHARES);
                if (gi == gj) begin : g_inner
                    logic iota_bit;
                    if (gi == 0 && gx == 0) begin : g_iota
                        assign iota_bit = iota_i;
                    end else begin : g_no_iota
                        assign iota_bit = 1'b0;
                    end
                    assign terms_o[T] = shares_i[gi*5+gx]
                                      ^ (~shares_i[gi*5+X1] & shares_i[gi*5+X2])
                                      ^ iota_bit;
                end else begin : g_cross
                    localparam int P = rand_idx(gi, gj);
                    assign terms_o[T] = (shares_i[gi*5+X1] & shares_i[gj*5+X2])
                                      ^ z_i[P*5+gx];
                end
            end
        end
    end

endmodule

// File: rtl/keccak_chi_dom_pipe.sv
// -----------------------------------------------------------------------------
// keccak_chi_dom_pipe
// Masked Keccak chi (+ optional iota) datapath, ROWS rows per beat, DOM with
// SHARES shares, two registered stages and valid/ready on every interface.
//   ClkxCI, RstxRBI      : clock (rising edge), asynchronous active-low reset
//   ClearxSI             : synchronous clear of valids, counter, RC and data
//   InValidxSI/InReadyxSO, InputxDI : input beat, share s row k bit x at (s*ROWS+k)*5+x
//   ZValidxSI, ZxDI      : fresh masks, pair p row k bit x at (p*ROWS+k)*5+x,
//                          consumed on the same edge as the input beat
//   IotaRCxDI            : round constant, captured on beat 0 of each round
//   OutValidxSO/OutReadyxSI, OutputxDO : result shares, same layout as input
//   OutLastxSO           : output beat is the last beat of its round
// Optional feature macro: KECCAK_CHI_IOTA_EN enables the RC register and the
// iota XOR; without it IotaRCxDI is ignored and the output is pure chi.
// -----------------------------------------------------------------------------
module keccak_chi_dom_pipe
    import keccak_dom_pkg::*;
#(
    parameter int SHARES   = 2,
    parameter int ROWS     = 5,
    parameter int W        = 64,
    parameter int NUM_RAND = calc_num_rand(SHARES)
) (
    input  logic                       ClkxCI,
    input  logic                       RstxRBI,
    input  logic                       ClearxSI,
    input  logic                       InValidxSI,
    output logic                       InReadyxSO,
    input  logic [SHARES*5*ROWS-1:0]   InputxDI,
    input  logic                       ZValidxSI,
    input  logic [NUM_RAND*5*ROWS-1:0] ZxDI,
    input  logic [W-1:0]               IotaRCxDI,
    output logic                       OutValidxSO,
    input  logic                       OutReadyxSI,
    output logic [SHARES*5*ROWS-1:0]   OutputxDO,
    output logic                       OutLastxSO
);

    localparam int BEATS = calc_beats(W, ROWS);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = SHARES * 5 * ROWS;
    localparam int TW    = SHARES * SHARES * 5;   // stage-1 terms per row

    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic [ROWS*TW-1:0]   s1_terms_q;
    logic [ROWS*TW-1:0]   s1_terms_d;
    logic                 s2_valid_q;
    logic                 s2_last_q;
    logic [DW-1:0]        out_q;
    logic [DW-1:0]        out_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 cnt_last;
    logic                 s1_adv;
    logic                 accept;

    // Stage 1 may move whenever the output slot is free or being drained, so
    // a full pipeline still sustains one beat per cycle.
    assign s1_adv     = ~s2_valid_q | OutReadyxSI;
    assign InReadyxSO = ~s1_valid_q | s1_adv;
    assign accept     = InValidxSI & ZValidxSI & InReadyxSO;
    assign cnt_last   = (cnt_q == CNT_W'(BEATS - 1));

`ifdef KECCAK_CHI_IOTA_EN
    localparam int RW  = $clog2(5 * W) + 1;
    localparam int ZIW = (W > 1) ? $clog2(W) : 1;
    logic [W-1:0] rc_q;
    logic [W-1:0] rc_cur;
    // Beat 0 uses the constant on the bus directly, since it is captured on
    // that same edge.
    assign rc_cur = (cnt_q == '0) ? IotaRCxDI : rc_q;
`else
    logic unused_rc;
    assign unused_rc = ^IotaRCxDI;
`endif

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [SHARES*5-1:0]   row_shares;
        logic [NUM_RAND*5-1:0] row_z;
        logic                  row_iota;

        for (genvar gs = 0; gs < SHARES; gs++) begin : g_sh
            assign row_shares[gs*5 +: 5] = InputxDI[share_off(gs, gi, 0, ROWS) +: 5];
        end
        for (genvar gp = 0; gp < NUM_RAND; gp++) begin : g_z
            assign row_z[gp*5 +: 5] = ZxDI[rand_off(gp, gi, 0, ROWS) +: 5];
        end

`ifdef KECCAK_CHI_IOTA_EN
        // Absolute row r = beat*ROWS + k; only lane y == 0 (r < W) takes RC[r].
        logic [RW-1:0] row_idx;
        assign row_idx  = RW'(cnt_q) * RW'(ROWS) + RW'(gi);
        assign row_iota = (row_idx < RW'(W)) ? rc_cur[row_idx[ZIW-1:0]] : 1'b0;
`else
        assign row_iota = 1'b0;
`endif

        keccak_chi_dom_row #(
            .SHARES   (SHARES),
            .NUM_RAND (NUM_RAND)
        ) u_row (
            .shares_i (row_shares),
            .z_i      (row_z),
            .iota_i   (row_iota),
            .terms_o  (s1_terms_d[gi*TW +: TW])
        );
    end

    // Stage 2 compression: per output share i, XOR over all partner shares j.
    always_comb begin
        out_d = '0;
        for (int k = 0; k < ROWS; k++) begin
            for (int i = 0; i < SHARES; i++) begin
                for (int j = 0; j < SHARES; j++) begin
                    for (int x = 0; x < 5; x++) begin
                        out_d[share_off(i, k, x, ROWS)] = out_d[share_off(i, k, x, ROWS)]
                            ^ s1_terms_q[k*TW + term_off(i, j, x, SHARES)];
                    end
                end
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_terms_q <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            out_q      <= '0;
`ifdef KECCAK_CHI_IOTA_EN
            rc_q       <= '0;
`endif
        end else if (ClearxSI) begin
            // Clear wins over a simultaneous accept: that beat is dropped.
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_terms_q <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            out_q      <= '0;
`ifdef KECCAK_CHI_IOTA_EN
            rc_q       <= '0;
`endif
        end else begin
            if (accept) begin
                cnt_q      <= cnt_last ? '0 : cnt_q + CNT_W'(1);
                s1_terms_q <= s1_terms_d;
                s1_last_q  <= cnt_last;
`ifdef KECCAK_CHI_IOTA_EN
                if (cnt_q == '0) begin
                    rc_q <= IotaRCxDI;
                end
`endif
            end
            if (InReadyxSO) begin
                s1_valid_q <= accept;
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
                s2_last_q  <= s1_valid_q & s1_last_q;
                if (s1_valid_q) begin
                    out_q <= out_d;
                end
            end
        end
    end

    assign OutputxDO   = out_q;
    assign OutValidxSO = s2_valid_q;
    assign OutLastxSO  = s2_last_q;

endmodule
